// File: rtl/fb_pkg.sv
// Shared constants, pixel entry and write-FSM state type for the
// framebuffer plot writer.
package fb_pkg;

   localparam int X_MAX     = 160;
   localparam int Y_MAX     = 120;
   localparam int FB_ADDR_W = 15;

   // One queued pixel: column, row and colour as produced by the drawing stage.
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pix_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      WRITE = 2'd2
   } wr_state_t;

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous pixel FIFO. A push against a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is discarded.
module plot_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic pop_i,
   input  pix_t din_i,
   output pix_t dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH;

   pix_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_MAX);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_ptr_q];

   // Storage array; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fb_plot_writer.sv
// Buffers plot strobes from the drawing stage and turns each in-range pixel
// into a framebuffer write (address = y*X_MAX + x) with a ready handshake.
module fb_plot_writer
   import fb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int X_MAX = fb_pkg::X_MAX,
   parameter int Y_MAX = fb_pkg::Y_MAX
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           vga_x,
   input  logic [6:0]           vga_y,
   input  logic [2:0]           vga_colour,
   input  logic                 vga_plot,
   output logic [FB_ADDR_W-1:0] fb_addr,
   output logic [2:0]           fb_data,
   output logic                 fb_we,
   input  logic                 fb_ready,
   output logic                 busy,
   output logic                 overflow,
   output logic [7:0]           drop_cnt,
   input  logic                 clr_flags
);

   localparam logic [8:0]           X_LIM = 9'(X_MAX);
   localparam logic [7:0]           Y_LIM = 8'(Y_MAX);
   localparam logic [FB_ADDR_W-1:0] X_MUL = FB_ADDR_W'(X_MAX);

   wr_state_t            state_q, state_d;
   pix_t                 ent_q, ent_d;
   pix_t                 in_pix, head;
   logic [FB_ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]           data_q, data_d;
   logic                 ovf_q, ovf_d;
   logic [7:0]           drop_q, drop_d;
   logic                 in_range, push, pop, full, empty;
   logic                 drop_evt, ovf_evt;

   assign in_range = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
   assign push     = vga_plot && in_range;
   assign drop_evt = vga_plot && !in_range;
   // A full FIFO still takes the pixel when the FSM pops in the same cycle.
   assign ovf_evt  = push && full && !pop;
   assign in_pix   = '{x: vga_x, y: vga_y, colour: vga_colour};

   plot_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (in_pix),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // Write FSM: pop into the entry register, compute the address, then hold
   // the write until the framebuffer accepts it.
   always_comb begin
      state_d = state_q;
      ent_d   = ent_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               ent_d   = head;
               state_d = ADDR;
            end
         end
         ADDR: begin
            addr_d  = FB_ADDR_W'(ent_q.y) * X_MUL + FB_ADDR_W'(ent_q.x);
            data_d  = ent_q.colour;
            state_d = WRITE;
         end
         WRITE: begin
            if (fb_ready) begin
               if (!empty) begin
                  pop     = 1'b1;
                  ent_d   = head;
                  state_d = ADDR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky flags: a clear lands first so an event in the same cycle survives it.
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (clr_flags) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
      if (ovf_evt) ovf_d = 1'b1;
      if (drop_evt && (drop_d != 8'hFF)) drop_d = drop_d + 8'd1;
   end

   // State, entry, output and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ent_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign fb_we    = (state_q == WRITE);
   assign fb_addr  = addr_q;
   assign fb_data  = data_q;
   assign busy     = !empty || (state_q != IDLE);
   assign overflow = ovf_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fb_plot_writer.sv
// Scoreboard bench for fb_plot_writer: expected writes are queued as plots
// are driven and popped when the framebuffer accepts a write.
module tb_fb_plot_writer;

   localparam int XM = 160;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  vga_x = '0;
   logic [6:0]  vga_y = '0;
   logic [2:0]  vga_colour = '0;
   logic        vga_plot = 1'b0;
   logic        fb_ready = 1'b1;
   logic        clr_flags = 1'b0;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_we, busy, overflow;
   logic [7:0]  drop_cnt;

   int          n_chk = 0;
   int          n_err = 0;
   int          n_wr  = 0;
   int          cyc   = 0;
   int          w0;
   logic [17:0] exp_q [$];
   int          wr_cyc [$];
   logic [17:0] mon_e;

   fb_plot_writer dut (
      .clk        (clk),
      .rst        (rst),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_we      (fb_we),
      .fb_ready   (fb_ready),
      .busy       (busy),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .clr_flags  (clr_flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Accepted writes are compared in order against the scoreboard.
   always @(negedge clk) begin
      if (fb_we && fb_ready) begin
         n_wr++;
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", int'(fb_addr), int'(mon_e[17:3]));
            chk("wr_data", int'(fb_data), int'(mon_e[2:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic plot(input int x, input int y, input int c);
      vga_x      = 8'(x);
      vga_y      = 7'(y);
      vga_colour = 3'(c);
      vga_plot   = 1'b1;
      tick();
      vga_plot   = 1'b0;
   endtask

   task automatic expect_wr(input int x, input int y, input int c);
      logic [14:0] a;
      a = 15'(y * XM + x);
      exp_q.push_back({a, 3'(c)});
   endtask

   task automatic plot_exp(input int x, input int y, input int c);
      expect_wr(x, y, c);
      plot(x, y, c);
   endtask

   task automatic clear_flags();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((busy || exp_q.size() != 0) && k < budget) begin
         tick();
         k++;
      end
      if (k >= budget) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with a plot strobe held during reset that must be ignored.
      rst = 1'b1;
      vga_x = 8'd1; vga_y = 7'd1; vga_plot = 1'b1;
      repeat (3) tick();
      vga_plot = 1'b0;
      @(negedge clk);
      chk("rst_we", fb_we, 0);
      chk("rst_addr", int'(fb_addr), 0);
      chk("rst_data", int'(fb_data), 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", int'(drop_cnt), 0);
      chk("rst_busy", busy, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_plot_ignored", busy, 0);

      // Single plot latency: strobe in cycle N, write visible in cycle N+3 only.
      w0 = n_wr;
      expect_wr(5, 3, 6);
      vga_x = 8'd5; vga_y = 7'd3; vga_colour = 3'd6; vga_plot = 1'b1;
      @(negedge clk); chk("lat_n0", fb_we, 0);
      tick(); vga_plot = 1'b0;
      @(negedge clk); chk("lat_n1", fb_we, 0);
      @(negedge clk); chk("lat_n2", fb_we, 0);
      @(negedge clk); chk("lat_n3", fb_we, 1);
      chk("lat_addr", int'(fb_addr), 485);
      chk("lat_data", int'(fb_data), 6);
      @(negedge clk); chk("lat_n4", fb_we, 0);
      tick();
      wait_idle(50);
      chk("single_writes", n_wr - w0, 1);

      // Edge of the frame: last pixel is written, one past it is dropped.
      w0 = n_wr;
      plot_exp(159, 119, 5);
      plot(160, 0, 2);
      wait_idle(50);
      chk("edge_writes", n_wr - w0, 1);
      chk("edge_drop", int'(drop_cnt), 1);
      plot(0, 120, 1);
      tick();
      chk("edge_drop_y", int'(drop_cnt), 2);
      chk("edge_busy", busy, 0);
      clear_flags();
      chk("edge_clr", int'(drop_cnt), 0);

      // Back-to-back burst: accepted writes two cycles apart.
      wr_cyc.delete();
      for (int i = 0; i < 4; i++) plot_exp(10 + i, 20, i + 1);
      wait_idle(50);
      chk("thru_count", wr_cyc.size(), 4);
      if (wr_cyc.size() == 4)
         for (int i = 1; i < 4; i++) chk("thru_gap", wr_cyc[i] - wr_cyc[i-1], 2);

      // Overflow: framebuffer stalled, six plots; the sixth is lost.
      w0 = n_wr;
      fb_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) plot_exp(i * 7, i + 1, i);
         else       plot(i * 7, i + 1, i);
      end
      repeat (3) tick();
      chk("ovf_set", overflow, 1);
      chk("ovf_stalled_writes", n_wr - w0, 0);
      fb_ready = 1'b1;
      wait_idle(100);
      chk("ovf_writes", n_wr - w0, 5);
      chk("ovf_sticky", overflow, 1);
      clear_flags();
      chk("ovf_clr", overflow, 0);

      // Clear coinciding with a drop: the drop counts after the clear.
      for (int i = 0; i < 3; i++) plot(200, 0, 0);
      chk("drop_pre", int'(drop_cnt), 3);
      clr_flags = 1'b1;
      plot(200, 0, 0);
      clr_flags = 1'b0;
      chk("clr_vs_drop", int'(drop_cnt), 1);
      clear_flags();

      // Drop counter saturation and clear.
      for (int i = 0; i < 300; i++) plot(200 + (i % 50), i % 128, i % 8);
      chk("drop_sat", int'(drop_cnt), 255);
      chk("drop_no_busy", busy, 0);
      clear_flags();
      chk("drop_clr", int'(drop_cnt), 0);

      // Full-frame column-major fill at one plot every two cycles.
      w0 = n_wr;
      for (int x = 0; x < XM; x++) begin
         for (int y = 0; y < 120; y++) begin
            plot_exp(x, y, (x + y) % 8);
            tick();
         end
      end
      wait_idle(100);
      chk("fill_writes", n_wr - w0, 19200);
      chk("fill_ovf", overflow, 0);

      // Reset while a write is held with three entries queued.
      fb_ready = 1'b0;
      for (int i = 0; i < 4; i++) plot(i, i, i);
      begin
         int k;
         k = 0;
         while (!fb_we && k < 20) begin
            tick();
            k++;
         end
      end
      chk("midrst_we_seen", fb_we, 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("midrst_we", fb_we, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      fb_ready = 1'b1;
      w0 = n_wr;
      repeat (20) tick();
      chk("midrst_no_writes", n_wr - w0, 0);
      chk("midrst_idle", busy, 0);

      chk("sb_leftover", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
